pickup_engine: RTL

PICKUP_ENGINE -- requirements
Module: pickup_engine

---
 rtl/pickup_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pickup_engine.sv
// pickup_engine: scans one coin slot per cycle, credits the lowest-index
// overlapping live tank, animates valid coins and respawns collected ones.
// Coin and score registers are writable over Avalon-MM.
module pickup_engine #(
   parameter int unsigned COIN_NUM    = 4,
   parameter int unsigned TANK_NUM    = 2,
   parameter int unsigned SCORE_W     = 16,
   parameter int unsigned TANK_SIZE   = 32,
   parameter int unsigned FRAME_DIV   = 2097152,
   parameter int unsigned RESPAWN_CYC = 0,
   parameter int unsigned COIN_BASE   = 2058,
   parameter int unsigned SCORE_BASE  = 2062
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   AVL_WRITE,
   input  logic [11:0]            AVL_ADDR,
   input  logic [31:0]            AVL_WRITEDATA,
   input  logic [10*TANK_NUM-1:0] tank_x,
   input  logic [10*TANK_NUM-1:0] tank_y,
   input  logic [TANK_NUM-1:0]    tank_alive,
   output logic [32*COIN_NUM-1:0] coin_attr_out,
   output logic [32*TANK_NUM-1:0] score_out,
   output logic [TANK_NUM-1:0]    collect_pulse
);
   localparam int unsigned SC_W  = (COIN_NUM > 1) ? $clog2(COIN_NUM) : 1;
   localparam int unsigned FD_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int unsigned RS_W  = (RESPAWN_CYC > 0) ? $clog2(RESPAWN_CYC + 1) : 1;
   localparam int unsigned CA_W  = 28;
   localparam int unsigned SUM_W = SCORE_W + 1;
   localparam int unsigned PX_W  = 11;

   // Coin attribute bits 27:0; bits 31:28 are reserved and never stored.
   logic [CA_W-1:0]    r_coin  [COIN_NUM];
   logic [RS_W-1:0]    r_resp  [COIN_NUM];
   logic [SCORE_W-1:0] r_score [TANK_NUM];
   logic [SC_W-1:0]    r_sc;
   logic [FD_W-1:0]    r_fdiv;

   logic [CA_W-1:0]     w_cur;
   logic [9:0]          w_cx;
   logic [9:0]          w_cy;
   logic [3:0]          w_val;
   logic [TANK_NUM-1:0] w_hit_vec;
   logic [TANK_NUM-1:0] w_win_oh;
   logic [COIN_NUM-1:0] w_coin_wr;
   logic [TANK_NUM-1:0] w_score_wr;
   logic                w_sc_wr;
   logic                w_take;
   logic                w_fwrap;
   logic [SUM_W-1:0]    w_sum [TANK_NUM];
   logic [SCORE_W-1:0]  w_sat [TANK_NUM];

   // Overlap test of the scanned coin against every tank; lowest index wins.
   always_comb begin
      w_cur     = r_coin[r_sc];
      w_cx      = w_cur[10:1];
      w_cy      = w_cur[20:11];
      w_val     = w_cur[27:24];
      w_hit_vec = '0;
      for (int t = 0; t < TANK_NUM; t++) begin
         w_hit_vec[t] = w_cur[0] && tank_alive[t]
            && (w_cx >= tank_x[10*t +: 10])
            && (PX_W'(w_cx) < (PX_W'(tank_x[10*t +: 10]) + PX_W'(TANK_SIZE)))
            && (w_cy >= tank_y[10*t +: 10])
            && (PX_W'(w_cy) < (PX_W'(tank_y[10*t +: 10]) + PX_W'(TANK_SIZE)));
      end
      w_win_oh = w_hit_vec & (~w_hit_vec + TANK_NUM'(1));
   end

   // Avalon address decode; a write to the scanned coin suppresses its hit.
   always_comb begin
      w_coin_wr  = '0;
      w_score_wr = '0;
      for (int i = 0; i < COIN_NUM; i++) begin
         w_coin_wr[i] = AVL_WRITE && (AVL_ADDR == 12'(COIN_BASE + i));
      end
      for (int t = 0; t < TANK_NUM; t++) begin
         w_score_wr[t] = AVL_WRITE && (AVL_ADDR == 12'(SCORE_BASE + t));
      end
      w_sc_wr = w_coin_wr[r_sc];
      w_take  = (|w_hit_vec) && !w_sc_wr;
      w_fwrap = (r_fdiv == FD_W'(FRAME_DIV - 1));
   end

   // Saturating score-plus-coin-value for each tank.
   always_comb begin
      for (int t = 0; t < TANK_NUM; t++) begin
         w_sum[t] = {1'b0, r_score[t]} + SUM_W'(w_val);
         w_sat[t] = w_sum[t][SCORE_W] ? {SCORE_W{1'b1}} : w_sum[t][SCORE_W-1:0];
      end
   end

   // Scan index, frame divider, coin slots, respawn counters, scores, pulses.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_sc          <= '0;
         r_fdiv        <= '0;
         collect_pulse <= '0;
         for (int i = 0; i < COIN_NUM; i++) begin
            r_coin[i] <= '0;
            r_resp[i] <= '0;
         end
         for (int t = 0; t < TANK_NUM; t++) begin
            r_score[t] <= '0;
         end
      end else begin
         r_sc          <= (r_sc == SC_W'(COIN_NUM - 1)) ? '0 : r_sc + SC_W'(1);
         r_fdiv        <= w_fwrap ? '0 : r_fdiv + FD_W'(1);
         collect_pulse <= w_take ? w_win_oh : '0;
         for (int i = 0; i < COIN_NUM; i++) begin
            if (w_coin_wr[i]) begin
               r_coin[i] <= AVL_WRITEDATA[CA_W-1:0];
               r_resp[i] <= '0;
            end else if (w_take && (r_sc == SC_W'(i))) begin
               r_coin[i][0] <= 1'b0;
               r_resp[i]    <= RS_W'(RESPAWN_CYC);
            end else if (!r_coin[i][0]) begin
               if ((RESPAWN_CYC > 0) && (r_resp[i] != '0)) begin
                  r_resp[i] <= r_resp[i] - RS_W'(1);
                  if (r_resp[i] == RS_W'(1)) begin
                     r_coin[i][0] <= 1'b1;
                  end
               end
            end else if (w_fwrap) begin
               r_coin[i][23:21] <= r_coin[i][23:21] + 3'd1;
            end
         end
         for (int t = 0; t < TANK_NUM; t++) begin
            if (w_score_wr[t]) begin
               r_score[t] <= AVL_WRITEDATA[SCORE_W-1:0];
            end else if (w_take && w_win_oh[t]) begin
               r_score[t] <= w_sat[t];
            end
         end
      end
   end

   // Output views of the registers: reserved coin bits and score MSBs read 0.
   always_comb begin
      for (int i = 0; i < COIN_NUM; i++) begin
         coin_attr_out[32*i +: 32] = {4'b0000, r_coin[i]};
      end
      for (int t = 0; t < TANK_NUM; t++) begin
         score_out[32*t +: 32] = 32'(r_score[t]);
      end
   end

endmodule
